// File: rtl/apb_interconnect_n.sv
// Registered APB4 bridge: one master fanned out to NUM_SLAVES slaves through a base/limit map,
// with a per-transaction PREADY timeout and error capture for the diagnostics path.
module apb_interconnect_n #(
  parameter int NUM_SLAVES = 5,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE =
    {32'h0002_B000, 32'h0002_A000, 32'h0002_8000, 32'h0000_8000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_LIMIT =
    {32'h0002_BFFF, 32'h0002_AFFF, 32'h0002_9FFF, 32'h0002_7FFF, 32'h0000_7FFF},
  parameter int unsigned TIMEOUT_CYCLES = 256,
  localparam int STRB_W = DATA_W / 8
) (
  input  logic                       pclk,
  input  logic                       preset_n,
  input  logic [ADDR_W-1:0]          m_paddr,
  input  logic                       m_psel,
  input  logic                       m_penable,
  input  logic                       m_pwrite,
  input  logic [DATA_W-1:0]          m_pwdata,
  input  logic [STRB_W-1:0]          m_pstrb,
  output logic                       m_pready,
  output logic [DATA_W-1:0]          m_prdata,
  output logic                       m_pslverr,
  output logic [ADDR_W-1:0]          s_paddr,
  output logic                       s_pwrite,
  output logic [DATA_W-1:0]          s_pwdata,
  output logic [STRB_W-1:0]          s_pstrb,
  output logic [NUM_SLAVES-1:0]      s_psel,
  output logic                       s_penable,
  input  logic [NUM_SLAVES-1:0]      s_pready,
  input  logic [NUM_SLAVES-1:0]      s_pslverr,
  input  logic [NUM_SLAVES*DATA_W-1:0] s_prdata,
  output logic                       err_valid,
  output logic [1:0]                 err_cause,
  output logic [ADDR_W-1:0]          err_addr,
  output logic [7:0]                 err_count
);

  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t            state, state_next;
  logic [IDX_W-1:0]  hit_idx, idx_q;
  logic              hit;
  logic [31:0]       to_cnt;
  logic              sel_ready, sel_err;
  logic [DATA_W-1:0] sel_rdata;
  logic              accept, enter_resp, resp_err;
  logic [1:0]        resp_cause;
  logic [DATA_W-1:0] resp_rdata;
  logic [ADDR_W-1:0] err_addr_next;

  // Walk from the top index down so the lowest matching slave wins on overlap.
  always_comb begin
    hit = 1'b0;
    hit_idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((m_paddr >= SLV_BASE[i*ADDR_W +: ADDR_W]) &&
          (m_paddr <= SLV_LIMIT[i*ADDR_W +: ADDR_W])) begin
        hit = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  assign sel_ready = s_pready[idx_q];
  assign sel_err   = s_pslverr[idx_q];
  assign sel_rdata = s_prdata[idx_q*DATA_W +: DATA_W];

  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A ready slave takes priority over the timeout in the same ACCESS cycle.
  always_comb begin
    state_next = state;
    accept = 1'b0;
    enter_resp = 1'b0;
    resp_err = 1'b0;
    resp_cause = 2'b00;
    resp_rdata = '0;
    err_addr_next = s_paddr;
    case (state)
      IDLE: begin
        err_addr_next = m_paddr;
        if (m_psel && !m_penable) begin
          accept = 1'b1;
          if (hit) begin
            state_next = SETUP;
          end else begin
            state_next = RESP;
            enter_resp = 1'b1;
            resp_err = 1'b1;
            resp_cause = 2'b01;
          end
        end
      end
      SETUP: state_next = ACCESS;
      ACCESS: begin
        if (sel_ready) begin
          state_next = RESP;
          enter_resp = 1'b1;
          resp_err = sel_err;
          resp_cause = 2'b11;
          resp_rdata = (s_pwrite || sel_err) ? '0 : sel_rdata;
        end else if ((TIMEOUT_CYCLES != 0) && ((to_cnt + 32'd1) == TIMEOUT_CYCLES)) begin
          state_next = RESP;
          enter_resp = 1'b1;
          resp_err = 1'b1;
          resp_cause = 2'b10;
        end
      end
      RESP: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      m_pready  <= 1'b0;
      m_prdata  <= '0;
      m_pslverr <= 1'b0;
      s_paddr   <= '0;
      s_pwrite  <= 1'b0;
      s_pwdata  <= '0;
      s_pstrb   <= '0;
      s_psel    <= '0;
      s_penable <= 1'b0;
      idx_q     <= '0;
      to_cnt    <= '0;
      err_valid <= 1'b0;
      err_cause <= 2'b00;
      err_addr  <= '0;
      err_count <= 8'd0;
    end else begin
      m_pready  <= enter_resp;
      m_prdata  <= resp_rdata;
      m_pslverr <= enter_resp && resp_err;
      err_valid <= enter_resp && resp_err;
      if (accept) begin
        s_paddr  <= m_paddr;
        s_pwrite <= m_pwrite;
        s_pwdata <= m_pwdata;
        s_pstrb  <= m_pstrb;
        idx_q    <= hit_idx;
        to_cnt   <= '0;
        if (hit) begin
          s_psel <= NUM_SLAVES'(1) << hit_idx;
        end
      end
      if (state == SETUP) begin
        s_penable <= 1'b1;
      end
      if (state == ACCESS) begin
        if (enter_resp) begin
          s_psel    <= '0;
          s_penable <= 1'b0;
        end else begin
          to_cnt <= to_cnt + 32'd1;
        end
      end
      if (enter_resp && resp_err) begin
        err_cause <= resp_cause;
        err_addr  <= err_addr_next;
        if (err_count != 8'hFF) begin
          err_count <= err_count + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_interconnect_n.sv
// Directed bench for apb_interconnect_n: a transaction-level model predicts every cycle's
// outputs, and literal checks pin the key latencies and data words.
module tb_apb_interconnect_n;

  localparam int NS = 5;
  localparam int TO = 4;

  localparam logic [31:0] BASE_TAB [NS] =
    '{32'h0000_0000, 32'h0000_8000, 32'h0002_8000, 32'h0002_A000, 32'h0002_B000};
  localparam logic [31:0] LIMIT_TAB [NS] =
    '{32'h0000_7FFF, 32'h0002_7FFF, 32'h0002_9FFF, 32'h0002_AFFF, 32'h0002_BFFF};

  logic          pclk = 1'b0;
  logic          preset_n;
  logic [31:0]   m_paddr;
  logic          m_psel, m_penable, m_pwrite;
  logic [31:0]   m_pwdata;
  logic [3:0]    m_pstrb;
  logic          m_pready;
  logic [31:0]   m_prdata;
  logic          m_pslverr;
  logic [31:0]   s_paddr;
  logic          s_pwrite;
  logic [31:0]   s_pwdata;
  logic [3:0]    s_pstrb;
  logic [NS-1:0] s_psel;
  logic          s_penable;
  logic [NS-1:0] s_pready, s_pslverr;
  logic [NS*32-1:0] s_prdata;
  logic          err_valid;
  logic [1:0]    err_cause;
  logic [31:0]   err_addr;
  logic [7:0]    err_count;

  apb_interconnect_n #(.NUM_SLAVES(NS), .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .pclk(pclk), .preset_n(preset_n),
    .m_paddr(m_paddr), .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
    .m_pwdata(m_pwdata), .m_pstrb(m_pstrb),
    .m_pready(m_pready), .m_prdata(m_prdata), .m_pslverr(m_pslverr),
    .s_paddr(s_paddr), .s_pwrite(s_pwrite), .s_pwdata(s_pwdata), .s_pstrb(s_pstrb),
    .s_psel(s_psel), .s_penable(s_penable),
    .s_pready(s_pready), .s_pslverr(s_pslverr), .s_prdata(s_prdata),
    .err_valid(err_valid), .err_cause(err_cause), .err_addr(err_addr), .err_count(err_count)
  );

  always #5 pclk = ~pclk;

  int total = 0;
  int bad = 0;

  logic          chk_en = 1'b0;
  logic [NS-1:0] exp_psel;
  logic          exp_pen, exp_mready, exp_mslverr, exp_errv, exp_req;
  logic [31:0]   exp_mrdata, exp_paddr, exp_pwdata;
  logic          exp_pwrite;
  logic [3:0]    exp_pstrb;
  logic [1:0]    mdl_cause = 2'b00;
  logic [31:0]   mdl_eaddr = 32'd0;
  logic [7:0]    mdl_ecnt = 8'd0;

  int            cur_rel, seen_rel;
  logic [31:0]   obs_rdata, obs_eaddr;
  logic          obs_slverr;
  logic [1:0]    obs_cause;
  logic [7:0]    obs_ecnt;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_decode(input logic [31:0] a);
    for (int i = 0; i < NS; i++) begin
      if (a >= BASE_TAB[i] && a <= LIMIT_TAB[i]) return i;
    end
    return -1;
  endfunction

  // Per-cycle comparison against whatever the driver predicted for this cycle.
  always @(negedge pclk) begin
    if (chk_en) begin
      check_output("s_psel", 32'(s_psel), 32'(exp_psel));
      check_output("s_penable", 32'(s_penable), 32'(exp_pen));
      check_output("m_pready", 32'(m_pready), 32'(exp_mready));
      check_output("err_valid", 32'(err_valid), 32'(exp_errv));
      check_output("err_cause", 32'(err_cause), 32'(mdl_cause));
      check_output("err_addr", err_addr, mdl_eaddr);
      check_output("err_count", 32'(err_count), 32'(mdl_ecnt));
      if (exp_mready) begin
        check_output("m_prdata", m_prdata, exp_mrdata);
        check_output("m_pslverr", 32'(m_pslverr), 32'(exp_mslverr));
      end
      if (exp_req) begin
        check_output("s_paddr", s_paddr, exp_paddr);
        check_output("s_pwrite", 32'(s_pwrite), 32'(exp_pwrite));
        check_output("s_pwdata", s_pwdata, exp_pwdata);
        check_output("s_pstrb", 32'(s_pstrb), 32'(exp_pstrb));
      end
      if (m_pready === 1'b1 && seen_rel < 0) seen_rel = cur_rel;
    end
  end

  task automatic idle_cycle();
    @(posedge pclk); #1;
    chk_en = 1'b1;
    m_psel = 1'b0; m_penable = 1'b0;
    s_pready = '0; s_pslverr = '0;
    exp_psel = '0; exp_pen = 1'b0; exp_mready = 1'b0; exp_errv = 1'b0; exp_req = 1'b0;
  endtask

  // One full master transaction; the slave-side behaviour is scripted by waits/serr/rdata.
  task automatic apply_stimulus(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                                input logic [3:0] strb, input int waits, input logic serr,
                                input logic [31:0] rdata);
    int idx, acc, resp_c;
    logic tmo, err;
    logic [1:0] cause;
    idx = model_decode(addr);
    tmo = 1'b0;
    acc = 0;
    if (idx < 0) begin
      resp_c = 1;
    end else begin
      acc = waits + 1;
      if (acc > TO) begin
        acc = TO;
        tmo = 1'b1;
      end
      resp_c = 2 + acc;
    end
    err = (idx < 0) || tmo || serr;
    cause = (idx < 0) ? 2'b01 : (tmo ? 2'b10 : 2'b11);
    for (int c = 0; c <= resp_c; c++) begin
      @(posedge pclk); #1;
      chk_en = 1'b1;
      cur_rel = c;
      if (c == 0) seen_rel = -1;
      m_psel = 1'b1; m_penable = (c > 0);
      m_paddr = addr; m_pwrite = wr; m_pwdata = wdata; m_pstrb = strb;
      for (int i = 0; i < NS; i++) s_prdata[i*32 +: 32] = 32'hBAD0_0000 + 32'(i);
      s_pready = '1;
      s_pslverr = '1;
      if (idx >= 0) begin
        s_prdata[idx*32 +: 32] = rdata;
        s_pready[idx] = !tmo && (c == 2 + waits);
        s_pslverr[idx] = serr;
      end
      exp_mready = (c == resp_c);
      exp_errv = (c == resp_c) && err;
      exp_mslverr = err;
      exp_mrdata = (!wr && !err) ? rdata : 32'd0;
      exp_psel = (idx >= 0 && c >= 1 && c < resp_c) ? (NS'(1) << idx) : '0;
      exp_pen = (idx >= 0 && c >= 2 && c < resp_c);
      exp_req = (idx >= 0 && c >= 1 && c < resp_c);
      exp_paddr = addr; exp_pwrite = wr; exp_pwdata = wdata; exp_pstrb = strb;
      if (c == resp_c && err) begin
        mdl_cause = cause;
        mdl_eaddr = addr;
        if (mdl_ecnt != 8'hFF) mdl_ecnt = mdl_ecnt + 8'd1;
      end
    end
    @(negedge pclk); #1;
    obs_rdata = m_prdata; obs_slverr = m_pslverr; obs_cause = err_cause;
    obs_eaddr = err_addr; obs_ecnt = err_count;
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_s_psel"}, 32'(s_psel), 32'd0);
    check_output({tag, "_s_penable"}, 32'(s_penable), 32'd0);
    check_output({tag, "_m_pready"}, 32'(m_pready), 32'd0);
    check_output({tag, "_m_prdata"}, m_prdata, 32'd0);
    check_output({tag, "_m_pslverr"}, 32'(m_pslverr), 32'd0);
    check_output({tag, "_s_paddr"}, s_paddr, 32'd0);
    check_output({tag, "_err_valid"}, 32'(err_valid), 32'd0);
    check_output({tag, "_err_cause"}, 32'(err_cause), 32'd0);
    check_output({tag, "_err_addr"}, err_addr, 32'd0);
    check_output({tag, "_err_count"}, 32'(err_count), 32'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    preset_n = 1'b0;
    m_paddr = '0; m_psel = 1'b0; m_penable = 1'b0; m_pwrite = 1'b0;
    m_pwdata = '0; m_pstrb = '0;
    s_pready = '0; s_pslverr = '0; s_prdata = '0;
    exp_psel = '0; exp_pen = 1'b0; exp_mready = 1'b0; exp_mslverr = 1'b0; exp_errv = 1'b0;
    exp_req = 1'b0; exp_mrdata = '0; exp_paddr = '0; exp_pwdata = '0; exp_pwrite = 1'b0;
    exp_pstrb = '0; cur_rel = 0; seen_rel = -1;
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    check_all_zero("reset");
    @(posedge pclk); #1;
    preset_n = 1'b1;

    $display("[TB] reset during ACCESS");
    @(posedge pclk); #1;
    m_psel = 1'b1; m_penable = 1'b0; m_paddr = 32'h0002_8004; m_pwrite = 1'b0;
    @(posedge pclk); #1;
    m_penable = 1'b1;
    @(negedge pclk);
    check_output("rst_setup_psel", 32'(s_psel), 32'b00100);
    check_output("rst_setup_pen", 32'(s_penable), 32'd0);
    @(negedge pclk);
    check_output("rst_access_pen", 32'(s_penable), 32'd1);
    @(posedge pclk); #1;
    preset_n = 1'b0; m_psel = 1'b0; m_penable = 1'b0;
    @(posedge pclk); #1;
    preset_n = 1'b1;
    @(negedge pclk);
    check_all_zero("midrst");

    $display("[TB] read slave 2 zero-wait");
    apply_stimulus(32'h0002_8004, 1'b0, 32'h0, 4'hF, 0, 1'b0, 32'hDEAD_BEEF);
    check_output("rd_ready_cycle", 32'(seen_rel), 32'd3);
    check_output("rd_data", obs_rdata, 32'hDEAD_BEEF);
    check_output("rd_slverr", 32'(obs_slverr), 32'd0);
    check_output("rd_errcnt", 32'(obs_ecnt), 32'd0);
    idle_cycle();

    $display("[TB] write decode miss");
    apply_stimulus(32'h0003_0000, 1'b1, 32'h1234_5678, 4'hF, 0, 1'b0, 32'h0);
    check_output("miss_ready_cycle", 32'(seen_rel), 32'd1);
    check_output("miss_slverr", 32'(obs_slverr), 32'd1);
    check_output("miss_cause", 32'(obs_cause), 32'd1);
    check_output("miss_addr", obs_eaddr, 32'h0003_0000);
    check_output("miss_count", 32'(obs_ecnt), 32'd1);
    idle_cycle();

    $display("[TB] timeout on slave 1");
    apply_stimulus(32'h0000_8000, 1'b0, 32'h0, 4'hF, 1000, 1'b0, 32'h1357_9BDF);
    check_output("tmo_ready_cycle", 32'(seen_rel), 32'd6);
    check_output("tmo_slverr", 32'(obs_slverr), 32'd1);
    check_output("tmo_data", obs_rdata, 32'd0);
    check_output("tmo_cause", 32'(obs_cause), 32'd2);
    idle_cycle();

    $display("[TB] slave 3 write with waits and PSLVERR");
    apply_stimulus(32'h0002_A010, 1'b1, 32'hCAFE_F00D, 4'b0011, 3, 1'b1, 32'h0);
    check_output("serr_ready_cycle", 32'(seen_rel), 32'd6);
    check_output("serr_slverr", 32'(obs_slverr), 32'd1);
    check_output("serr_cause", 32'(obs_cause), 32'd3);
    check_output("serr_count", 32'(obs_ecnt), 32'd3);
    idle_cycle();

    $display("[TB] back-to-back reads");
    apply_stimulus(32'h0000_0010, 1'b0, 32'h0, 4'hF, 0, 1'b0, 32'h0000_A5A5);
    check_output("b2b_rom_data", obs_rdata, 32'h0000_A5A5);
    apply_stimulus(32'h0002_B020, 1'b0, 32'h0, 4'hF, 0, 1'b0, 32'hC0FF_EE00);
    check_output("b2b_diag_cycle", 32'(seen_rel), 32'd3);
    check_output("b2b_diag_data", obs_rdata, 32'hC0FF_EE00);

    $display("[TB] map boundaries");
    apply_stimulus(32'h0000_7FFF, 1'b0, 32'h0, 4'hF, 2, 1'b0, 32'h1111_2222);
    apply_stimulus(32'h0000_8000, 1'b1, 32'hA5A5_5A5A, 4'b0101, 0, 1'b0, 32'h0);
    idle_cycle();
    apply_stimulus(32'h0002_7FFF, 1'b0, 32'h0, 4'hF, 1, 1'b0, 32'h3333_4444);
    apply_stimulus(32'h0002_9FFF, 1'b0, 32'h0, 4'hF, 0, 1'b1, 32'h5555_6666);
    check_output("rd_serr_data", obs_rdata, 32'd0);
    apply_stimulus(32'h0002_BFFF, 1'b1, 32'h7777_8888, 4'b1000, 2, 1'b0, 32'h0);
    apply_stimulus(32'h0002_C000, 1'b0, 32'h0, 4'hF, 0, 1'b0, 32'h0);
    apply_stimulus(32'h0002_A000, 1'b0, 32'h0, 4'hF, 3, 1'b0, 32'h9999_AAAA);
    check_output("edge_wait_data", obs_rdata, 32'h9999_AAAA);
    check_output("edge_wait_cycle", 32'(seen_rel), 32'd6);
    idle_cycle();

    $display("[TB] error count saturation");
    for (int k = 0; k < 300; k++) begin
      apply_stimulus(32'h0003_0000 + 32'(k * 4), (k % 2) == 1, 32'(k), 4'hF, 0, 1'b0, 32'h0);
    end
    check_output("sat_count", 32'(obs_ecnt), 32'd255);
    check_output("sat_cause", 32'(obs_cause), 32'd1);
    idle_cycle();

    apply_stimulus(32'h0002_8004, 1'b0, 32'h0, 4'hF, 0, 1'b0, 32'h600D_F00D);
    check_output("final_data", obs_rdata, 32'h600D_F00D);
    idle_cycle();
    @(posedge pclk);
    chk_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
